// File: rtl/hyperbus_axi_bist.sv
// rtl/hyperbus_axi_bist.sv - AXI4 write/read-back memory BIST for the HyperBus AXI slave port
//
// Purpose: writes NUM_BURSTS INCR bursts of (word index ^ SEED) through a 16-bit
// AXI4 initiator port, reads them back, compares, and reports done/pass/error count.
// Optional watchdog abort: define HYPERBUS_BIST_TIMEOUT_EN.
//
// Ports:
//   clk_sys_i, rst_ni                  clock, asynchronous active-low reset
//   start_i                            start pulse, accepted only in IDLE or DONE
//   busy_o, done_o, pass_o             pass status
//   err_count_o                        saturating mismatch/response error count
//   timeout_o                          sticky watchdog abort flag (0 without watchdog)
//   axi_o_aw_*, axi_o_w_*, axi_o_b_*   write address / data / response channels
//   axi_o_ar_*, axi_o_r_*              read address / data channels
module hyperbus_axi_bist #(
   parameter int unsigned       AXI_AW     = 32,
   parameter int unsigned       AXI_IW     = 10,
   parameter int unsigned       AXI_UW     = 1,
   parameter int unsigned       BURST_LEN  = 16,
   parameter int unsigned       NUM_BURSTS = 4,
   parameter logic [AXI_AW-1:0] BASE_ADDR  = '0,
   parameter logic [15:0]       SEED       = 16'hA5C3,
   parameter int unsigned       TIMEOUT    = 1024
) (
   input  logic              clk_sys_i,
   input  logic              rst_ni,
   input  logic              start_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              pass_o,
   output logic [15:0]       err_count_o,
   output logic              timeout_o,
   output logic [AXI_IW-1:0] axi_o_aw_id,
   output logic [AXI_AW-1:0] axi_o_aw_addr,
   output logic [7:0]        axi_o_aw_len,
   output logic [2:0]        axi_o_aw_size,
   output logic [1:0]        axi_o_aw_burst,
   output logic              axi_o_aw_lock,
   output logic [3:0]        axi_o_aw_cache,
   output logic [2:0]        axi_o_aw_prot,
   output logic [3:0]        axi_o_aw_qos,
   output logic [3:0]        axi_o_aw_region,
   output logic [AXI_UW-1:0] axi_o_aw_user,
   output logic              axi_o_aw_valid,
   input  logic              axi_o_aw_ready,
   output logic [15:0]       axi_o_w_data,
   output logic [1:0]        axi_o_w_strb,
   output logic              axi_o_w_last,
   output logic [AXI_UW-1:0] axi_o_w_user,
   output logic              axi_o_w_valid,
   input  logic              axi_o_w_ready,
   input  logic [AXI_IW-1:0] axi_o_b_id,
   input  logic [1:0]        axi_o_b_resp,
   input  logic [AXI_UW-1:0] axi_o_b_user,
   input  logic              axi_o_b_valid,
   output logic              axi_o_b_ready,
   output logic [AXI_IW-1:0] axi_o_ar_id,
   output logic [AXI_AW-1:0] axi_o_ar_addr,
   output logic [7:0]        axi_o_ar_len,
   output logic [2:0]        axi_o_ar_size,
   output logic [1:0]        axi_o_ar_burst,
   output logic              axi_o_ar_lock,
   output logic [3:0]        axi_o_ar_cache,
   output logic [2:0]        axi_o_ar_prot,
   output logic [3:0]        axi_o_ar_qos,
   output logic [3:0]        axi_o_ar_region,
   output logic [AXI_UW-1:0] axi_o_ar_user,
   output logic              axi_o_ar_valid,
   input  logic              axi_o_ar_ready,
   input  logic [AXI_IW-1:0] axi_o_r_id,
   input  logic [15:0]       axi_o_r_data,
   input  logic [1:0]        axi_o_r_resp,
   input  logic              axi_o_r_last,
   input  logic [AXI_UW-1:0] axi_o_r_user,
   input  logic              axi_o_r_valid,
   output logic              axi_o_r_ready
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WR_AW = 3'd1;
   localparam logic [2:0] S_WR_W  = 3'd2;
   localparam logic [2:0] S_WR_B  = 3'd3;
   localparam logic [2:0] S_RD_AR = 3'd4;
   localparam logic [2:0] S_RD_R  = 3'd5;
   localparam logic [2:0] S_DONE  = 3'd6;

   localparam int unsigned       BW         = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
   localparam logic [BW-1:0]     LAST_BURST = BW'(NUM_BURSTS - 1);
   localparam logic [7:0]        LAST_BEAT  = 8'(BURST_LEN - 1);
   localparam logic [AXI_AW-1:0] STRIDE     = AXI_AW'(BURST_LEN * 2);

   logic [2:0]        state_q, state_d;
   logic [BW-1:0]     burst_q, burst_d;
   logic [7:0]        beat_q, beat_d;
   logic [15:0]       word_q, word_d;   // global word index n within the current phase
   logic [AXI_AW-1:0] addr_q, addr_d;
   logic [15:0]       err_q, err_d;
   logic              start_ok, err_hit, wdog_fire;
   logic              aw_hs, w_hs, b_hs, ar_hs, r_hs;
   logic              beat_last, burst_last;
   logic [15:0]       exp_data;

   logic unused_inputs;
   assign unused_inputs = ^{axi_o_b_id, axi_o_b_user, axi_o_r_id, axi_o_r_user};

   assign exp_data   = word_q ^ SEED;
   assign beat_last  = (beat_q == LAST_BEAT);
   assign burst_last = (burst_q == LAST_BURST);

   // Valids and readies are pure functions of state, so an async reset
   // drops them in the same cycle and they never wait on the other side.
   assign axi_o_aw_valid = (state_q == S_WR_AW);
   assign axi_o_w_valid  = (state_q == S_WR_W);
   assign axi_o_b_ready  = (state_q == S_WR_B);
   assign axi_o_ar_valid = (state_q == S_RD_AR);
   assign axi_o_r_ready  = (state_q == S_RD_R);

   assign aw_hs = axi_o_aw_valid & axi_o_aw_ready;
   assign w_hs  = axi_o_w_valid  & axi_o_w_ready;
   assign b_hs  = axi_o_b_ready  & axi_o_b_valid;
   assign ar_hs = axi_o_ar_valid & axi_o_ar_ready;
   assign r_hs  = axi_o_r_ready  & axi_o_r_valid;

   assign axi_o_aw_id     = '0;
   assign axi_o_aw_addr   = addr_q;
   assign axi_o_aw_len    = LAST_BEAT;
   assign axi_o_aw_size   = 3'b001;
   assign axi_o_aw_burst  = 2'b01;
   assign axi_o_aw_lock   = 1'b0;
   assign axi_o_aw_cache  = 4'b0011;
   assign axi_o_aw_prot   = '0;
   assign axi_o_aw_qos    = '0;
   assign axi_o_aw_region = '0;
   assign axi_o_aw_user   = '0;

   assign axi_o_ar_id     = '0;
   assign axi_o_ar_addr   = addr_q;
   assign axi_o_ar_len    = LAST_BEAT;
   assign axi_o_ar_size   = 3'b001;
   assign axi_o_ar_burst  = 2'b01;
   assign axi_o_ar_lock   = 1'b0;
   assign axi_o_ar_cache  = 4'b0011;
   assign axi_o_ar_prot   = '0;
   assign axi_o_ar_qos    = '0;
   assign axi_o_ar_region = '0;
   assign axi_o_ar_user   = '0;

   assign axi_o_w_data = exp_data;
   assign axi_o_w_strb = 2'b11;
   assign axi_o_w_last = beat_last;
   assign axi_o_w_user = '0;

   assign start_ok    = start_i & ((state_q == S_IDLE) | (state_q == S_DONE));
   assign busy_o      = ~((state_q == S_IDLE) | (state_q == S_DONE));
   assign done_o      = (state_q == S_DONE);
   assign pass_o      = done_o & (err_q == 16'd0) & ~timeout_o;
   assign err_count_o = err_q;

   always_comb begin
      state_d = state_q;
      burst_d = burst_q;
      beat_d  = beat_q;
      word_d  = word_q;
      addr_d  = addr_q;
      err_hit = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_i) begin
               state_d = S_WR_AW;
               burst_d = '0;
               beat_d  = '0;
               word_d  = '0;
               addr_d  = BASE_ADDR;
            end
         end
         S_WR_AW: begin
            if (aw_hs) begin
               state_d = S_WR_W;
               beat_d  = '0;
            end
         end
         S_WR_W: begin
            if (w_hs) begin
               word_d = word_q + 16'd1;
               beat_d = beat_q + 8'd1;
               if (beat_last) state_d = S_WR_B;
            end
         end
         S_WR_B: begin
            if (b_hs) begin
               err_hit = (axi_o_b_resp != 2'b00);
               if (burst_last) begin
                  state_d = S_RD_AR;
                  burst_d = '0;
                  word_d  = '0;
                  addr_d  = BASE_ADDR;
               end else begin
                  state_d = S_WR_AW;
                  burst_d = burst_q + BW'(1);
                  addr_d  = addr_q + STRIDE;
               end
            end
         end
         S_RD_AR: begin
            if (ar_hs) begin
               state_d = S_RD_R;
               beat_d  = '0;
            end
         end
         S_RD_R: begin
            if (r_hs) begin
               // One increment per beat no matter how many checks it fails.
               err_hit = (axi_o_r_resp != 2'b00) | (axi_o_r_data != exp_data) |
                         (axi_o_r_last != beat_last);
               word_d  = word_q + 16'd1;
               beat_d  = beat_q + 8'd1;
               // Burst end is decided by the beat counter, never by r_last.
               if (beat_last) begin
                  if (burst_last) begin
                     state_d = S_DONE;
                  end else begin
                     state_d = S_RD_AR;
                     burst_d = burst_q + BW'(1);
                     addr_d  = addr_q + STRIDE;
                  end
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (wdog_fire) state_d = S_DONE;

      if (start_ok)
         err_d = '0;
      else if (err_hit && (err_q != 16'hFFFF))
         err_d = err_q + 16'd1;
      else
         err_d = err_q;
   end

   always_ff @(posedge clk_sys_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         burst_q <= '0;
         beat_q  <= '0;
         word_q  <= '0;
         addr_q  <= BASE_ADDR;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         burst_q <= burst_d;
         beat_q  <= beat_d;
         word_q  <= word_d;
         addr_q  <= addr_d;
         err_q   <= err_d;
      end
   end

`ifdef HYPERBUS_BIST_TIMEOUT_EN
   localparam int unsigned   TW      = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT - 1);

   logic [TW-1:0] wdog_q, wdog_d;
   logic          tmo_q, tmo_d, any_hs;

   assign any_hs    = aw_hs | w_hs | b_hs | ar_hs | r_hs;
   assign timeout_o = tmo_q;

   // Counts consecutive busy cycles without any handshake.
   always_comb begin
      wdog_d    = wdog_q;
      tmo_d     = tmo_q;
      wdog_fire = 1'b0;
      if (start_ok) begin
         wdog_d = '0;
         tmo_d  = 1'b0;
      end else if (busy_o) begin
         if (any_hs) begin
            wdog_d = '0;
         end else if (wdog_q == WD_LAST) begin
            wdog_fire = 1'b1;
            tmo_d     = 1'b1;
            wdog_d    = '0;
         end else begin
            wdog_d = wdog_q + TW'(1);
         end
      end
   end

   always_ff @(posedge clk_sys_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wdog_q <= '0;
         tmo_q  <= 1'b0;
      end else begin
         wdog_q <= wdog_d;
         tmo_q  <= tmo_d;
      end
   end
`else
   assign wdog_fire = 1'b0;
   assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_hyperbus_axi_bist.sv
// tb/tb_hyperbus_axi_bist.sv - self-checking bench for hyperbus_axi_bist with a behavioural slave model
module tb_hyperbus_axi_bist;
   localparam int          BL   = 16;
   localparam int          NB   = 4;
   localparam logic [15:0] SEED = 16'hA5C3;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic start = 1'b0;
   logic busy_o, done_o, pass_o, timeout_o;
   logic [15:0] err_count_o;

   logic [9:0]  aw_id, ar_id;
   logic [31:0] aw_addr, ar_addr;
   logic [7:0]  aw_len, ar_len;
   logic [2:0]  aw_size, ar_size, aw_prot, ar_prot;
   logic [1:0]  aw_burst, ar_burst;
   logic        aw_lock, ar_lock;
   logic [3:0]  aw_cache, ar_cache, aw_qos, ar_qos, aw_region, ar_region;
   logic [0:0]  aw_user, ar_user, w_user;
   logic        aw_valid, w_valid, ar_valid, b_ready, r_ready;
   logic [15:0] w_data;
   logic [1:0]  w_strb;
   logic        w_last;

   logic        aw_ready = 1'b0, w_ready = 1'b0, ar_ready = 1'b0;
   logic [9:0]  b_id = '0, r_id = '0;
   logic [0:0]  b_user = '0, r_user = '0;
   logic [1:0]  b_resp = '0, r_resp = '0;
   logic        b_valid = 1'b0, r_valid = 1'b0, r_last = 1'b0;
   logic [15:0] r_data = '0;

   hyperbus_axi_bist dut (
      .clk_sys_i(clk), .rst_ni(rst_n), .start_i(start),
      .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o),
      .err_count_o(err_count_o), .timeout_o(timeout_o),
      .axi_o_aw_id(aw_id), .axi_o_aw_addr(aw_addr), .axi_o_aw_len(aw_len),
      .axi_o_aw_size(aw_size), .axi_o_aw_burst(aw_burst), .axi_o_aw_lock(aw_lock),
      .axi_o_aw_cache(aw_cache), .axi_o_aw_prot(aw_prot), .axi_o_aw_qos(aw_qos),
      .axi_o_aw_region(aw_region), .axi_o_aw_user(aw_user),
      .axi_o_aw_valid(aw_valid), .axi_o_aw_ready(aw_ready),
      .axi_o_w_data(w_data), .axi_o_w_strb(w_strb), .axi_o_w_last(w_last),
      .axi_o_w_user(w_user), .axi_o_w_valid(w_valid), .axi_o_w_ready(w_ready),
      .axi_o_b_id(b_id), .axi_o_b_resp(b_resp), .axi_o_b_user(b_user),
      .axi_o_b_valid(b_valid), .axi_o_b_ready(b_ready),
      .axi_o_ar_id(ar_id), .axi_o_ar_addr(ar_addr), .axi_o_ar_len(ar_len),
      .axi_o_ar_size(ar_size), .axi_o_ar_burst(ar_burst), .axi_o_ar_lock(ar_lock),
      .axi_o_ar_cache(ar_cache), .axi_o_ar_prot(ar_prot), .axi_o_ar_qos(ar_qos),
      .axi_o_ar_region(ar_region), .axi_o_ar_user(ar_user),
      .axi_o_ar_valid(ar_valid), .axi_o_ar_ready(ar_ready),
      .axi_o_r_id(r_id), .axi_o_r_data(r_data), .axi_o_r_resp(r_resp),
      .axi_o_r_last(r_last), .axi_o_r_user(r_user),
      .axi_o_r_valid(r_valid), .axi_o_r_ready(r_ready)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // scenario knobs
   bit bp_en = 0;
   bit early_last = 0;
   bit aw_block = 0;
   int corrupt_n = -1;
   int slverr_b = -1;

   // slave / model state
   logic [15:0] mem [0:1023];
   int  aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
   int  wbase, wbeat, rd_base, rd_beat, rd_burst, idle;
   bit  wr_open, b_pend, rd_open, b_hold, r_hold;
   bit  started, mdone, mtmo;
   int  exp_err;
   logic [31:0] aw_log [0:3];
   logic [15:0] first_w_data;
   bit  p_aw_st, p_w_st, p_ar_st;
   logic [31:0] p_aw_addr, p_ar_addr;
   logic [16:0] p_w_pay;
   bit  aw_hs, w_hs, b_hs, ar_hs, r_hs, bad;

   function automatic bit rnd();
      return bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
   endfunction

   function automatic logic [39:0] attr_exp();
      return {8'(BL - 1), 3'd1, 2'd1, 4'd3, 1'b0, 3'd0, 4'd0, 4'd0, 10'd0, 1'b0};
   endfunction

   always begin
      @(negedge clk);
      if (!rst_n) begin
         aw_ready = 0; w_ready = 0; ar_ready = 0; b_valid = 0; r_valid = 0;
         b_hold = 0; r_hold = 0;
      end else begin
         aw_ready = aw_block ? 1'b0 : rnd();
         w_ready  = rnd();
         ar_ready = rnd();
         b_valid  = b_pend && (b_hold || rnd());
         b_hold   = b_valid;
         b_resp   = (b_cnt == slverr_b) ? 2'b10 : 2'b00;
         r_valid  = rd_open && (r_hold || rnd());
         r_hold   = r_valid;
         r_data   = rd_open ? (mem[(rd_base + rd_beat) % 1024] ^ ((r_cnt == corrupt_n) ? 16'h0001 : 16'h0000)) : 16'h0000;
         r_last   = (early_last && rd_burst == 0) ? (rd_beat == 14) : (rd_beat == BL - 1);
         r_resp   = 2'b00;
      end
      #1;
      if (!rst_n) begin
         chk("rst_outputs", 64'({aw_valid, w_valid, ar_valid, b_ready, r_ready, busy_o, done_o, timeout_o, err_count_o}), 64'd0);
         started = 0; mdone = 0; mtmo = 0; exp_err = 0; idle = 0;
         wr_open = 0; b_pend = 0; rd_open = 0;
         p_aw_st = 0; p_w_st = 0; p_ar_st = 0;
      end else begin
         chk("busy", 64'(busy_o), 64'(started && !mdone));
         chk("done", 64'(done_o), 64'(mdone));
         chk("pass", 64'(pass_o), 64'(mdone && exp_err == 0 && !mtmo));
         chk("err_count", 64'(err_count_o), 64'(exp_err));
         chk("timeout", 64'(timeout_o), 64'(mtmo));
         chk("b_ready", 64'(b_ready), 64'(b_pend));
         chk("r_ready", 64'(r_ready), 64'(rd_open));
         if (!started || mdone) chk("idle_valids", 64'({aw_valid, w_valid, ar_valid}), 64'd0);

         aw_hs = aw_valid && aw_ready;
         w_hs  = w_valid && w_ready;
         b_hs  = b_valid && b_ready;
         ar_hs = ar_valid && ar_ready;
         r_hs  = r_valid && r_ready;

         if (p_aw_st && !mdone) chk("aw_hold", 64'({aw_valid, aw_addr}), 64'({1'b1, p_aw_addr}));
         if (p_w_st && !mdone)  chk("w_hold", 64'({w_valid, w_last, w_data}), 64'({1'b1, p_w_pay}));
         if (p_ar_st && !mdone) chk("ar_hold", 64'({ar_valid, ar_addr}), 64'({1'b1, p_ar_addr}));

         if (aw_hs) begin
            chk("aw_addr", 64'(aw_addr), 64'(aw_cnt * BL * 2));
            chk("aw_attr", 64'({aw_len, aw_size, aw_burst, aw_cache, aw_lock, aw_prot, aw_qos, aw_region, aw_id, aw_user}), 64'(attr_exp()));
            chk("aw_single", 64'({wr_open, b_pend, rd_open}), 64'd0);
            if (aw_cnt < 4) aw_log[aw_cnt] = aw_addr;
            wr_open = 1; wbase = int'(aw_addr >> 1); wbeat = 0; aw_cnt++;
         end
         if (w_hs) begin
            chk("w_after_aw", 64'(wr_open), 64'd1);
            chk("w_data", 64'(w_data), 64'(16'(w_cnt) ^ SEED));
            chk("w_last_strb", 64'({w_last, w_strb}), 64'({wbeat == BL - 1, 2'b11}));
            if (w_cnt == 0) first_w_data = w_data;
            mem[(wbase + wbeat) % 1024] = w_data;
            w_cnt++; wbeat++;
            if (wbeat == BL) begin wr_open = 0; b_pend = 1; end
         end
         if (b_hs) begin
            if (b_resp != 2'b00) exp_err++;
            b_cnt++; b_pend = 0;
         end
         if (ar_hs) begin
            chk("ar_addr", 64'(ar_addr), 64'(ar_cnt * BL * 2));
            chk("ar_attr", 64'({ar_len, ar_size, ar_burst, ar_cache, ar_lock, ar_prot, ar_qos, ar_region, ar_id, ar_user}), 64'(attr_exp()));
            chk("ar_order", 64'({b_cnt == NB, rd_open}), 64'b10);
            rd_open = 1; rd_base = int'(ar_addr >> 1); rd_beat = 0; rd_burst = ar_cnt; ar_cnt++;
         end
         if (r_hs) begin
            bad = (r_resp != 2'b00) || (r_data != (16'(r_cnt) ^ SEED)) || (r_last != (rd_beat == BL - 1));
            if (bad) exp_err++;
            r_cnt++; rd_beat++;
            if (rd_beat == BL) begin
               rd_open = 0;
               if (ar_cnt == NB) mdone = 1;
            end
         end
`ifdef HYPERBUS_BIST_TIMEOUT_EN
         if (started && !mdone) begin
            if (aw_hs || w_hs || b_hs || ar_hs || r_hs) idle = 0;
            else idle++;
            if (idle == 1024) begin mdone = 1; mtmo = 1; idle = 0; end
         end
`endif
         if (start && (!started || mdone)) begin
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
            wr_open = 0; b_pend = 0; rd_open = 0;
            started = 1; mdone = 0; mtmo = 0; exp_err = 0; idle = 0;
         end
         p_aw_st = aw_valid && !aw_hs; p_aw_addr = aw_addr;
         p_w_st  = w_valid && !w_hs;   p_w_pay   = {w_last, w_data};
         p_ar_st = ar_valid && !ar_hs; p_ar_addr = ar_addr;
      end
   end

   task automatic pulse_start();
      @(negedge clk); start = 1;
      @(negedge clk); start = 0;
   endtask

   task automatic run_pass(input string name);
      bit seen;
      seen = 0;
      pulse_start();
      for (int i = 0; i < 4000 && !seen; i++) begin
         @(negedge clk); #2;
         seen = done_o;
      end
      chk({name, "_done_seen"}, 64'(seen), 64'd1);
   endtask

   initial begin
      bit seen;
      #1 rst_n = 0;
      repeat (3) @(negedge clk);
      #2;
      chk("rst_status", 64'({busy_o, done_o, pass_o, timeout_o, err_count_o}), 64'd0);
      chk("rst_valids", 64'({aw_valid, w_valid, ar_valid, b_ready, r_ready}), 64'd0);
      @(negedge clk); rst_n = 1;

      run_pass("ideal");
      chk("ideal_result", 64'({done_o, pass_o, err_count_o}), 64'({1'b1, 1'b1, 16'd0}));
      chk("ideal_w_beats", 64'(w_cnt), 64'd64);
      chk("ideal_r_beats", 64'(r_cnt), 64'd64);
      chk("first_w_data", 64'(first_w_data), 64'h A5C3);
      chk("aw_addr0", 64'(aw_log[0]), 64'd0);
      chk("aw_addr1", 64'(aw_log[1]), 64'd32);
      chk("aw_addr2", 64'(aw_log[2]), 64'd64);
      chk("aw_addr3", 64'(aw_log[3]), 64'd96);

      bp_en = 1;
      run_pass("backpressure");
      chk("bp_result", 64'({done_o, pass_o, err_count_o}), 64'({1'b1, 1'b1, 16'd0}));
      chk("bp_r_beats", 64'(r_cnt), 64'd64);
      bp_en = 0;

      corrupt_n = 5; slverr_b = 2;
      run_pass("corrupt");
      chk("corrupt_result", 64'({pass_o, err_count_o}), 64'({1'b0, 16'd2}));
      corrupt_n = -1; slverr_b = -1;

      early_last = 1;
      run_pass("early_last");
      chk("early_last_result", 64'({pass_o, err_count_o}), 64'({1'b0, 16'd2}));
      chk("early_last_r_beats", 64'(r_cnt), 64'd64);
      early_last = 0;

      pulse_start();
      seen = 0;
      for (int i = 0; i < 2000 && !seen; i++) begin
         @(negedge clk); #2;
         seen = r_ready;
      end
      chk("reach_rd_r", 64'(seen), 64'd1);
      @(posedge clk); #2;
      rst_n = 0;
      #1;
      chk("midrst_status", 64'({busy_o, done_o, pass_o, timeout_o, err_count_o}), 64'd0);
      chk("midrst_valids", 64'({aw_valid, w_valid, ar_valid, b_ready, r_ready}), 64'd0);
      @(negedge clk); @(negedge clk);
      rst_n = 1;
      run_pass("after_rst");
      chk("after_rst_result", 64'({done_o, pass_o, err_count_o}), 64'({1'b1, 1'b1, 16'd0}));

`ifdef HYPERBUS_BIST_TIMEOUT_EN
      aw_block = 1;
      run_pass("timeout");
      chk("timeout_result", 64'({timeout_o, done_o, pass_o, aw_valid}), 64'b1100);
      aw_block = 0;
      run_pass("post_timeout");
      chk("post_timeout_result", 64'({timeout_o, pass_o}), 64'b01);
`endif

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
